// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes a shift op into shifter controls and holds it in a
// 2-entry skid buffer (main M drives outputs, skid S absorbs one op of back-pressure).
// Optional feature macro: SHIFT_ISSUE_ERR_EN -- adds the err port and drops illegal ops;
// when undefined, illegal ops are issued as sll-by-0 pass-throughs.
module shift_issue_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [4:0]        imm_shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sh_in,
  output logic [DATA_W-1:0] sh_shamt,
  output logic              sh_dir,
  output logic              sh_aorl
`ifdef SHIFT_ISSUE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned SHAMT_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0]  val;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic               aorl;
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  op_t    m_q, m_d;
  op_t    s_q, s_d;
  logic   out_valid_q;
  logic   in_ready_q;
  op_t    dec;
  logic   illegal;
  logic   in_xfer;
  logic   enq;
  logic   out_xfer;

  // Only the low shift-amount bits of rs_val are meaningful.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_val[DATA_W-1:SHAMT_W];

  // Decode funct and operands into shifter controls.
  always_comb begin
    illegal   = (funct[1:0] == 2'b11);
    dec       = '0;
    dec.val   = rt_val;
    dec.shamt = funct[2] ? rs_val[SHAMT_W-1:0] : imm_shamt;
    dec.dir   = (funct[1:0] == 2'b00);
    dec.aorl  = (funct[1:0] == 2'b10);
`ifndef SHIFT_ISSUE_ERR_EN
    if (illegal) begin
      dec.shamt = '0;
      dec.dir   = 1'b1;
      dec.aorl  = 1'b0;
    end
`endif
  end

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;
`ifdef SHIFT_ISSUE_ERR_EN
  assign enq = in_xfer & ~illegal;
`else
  assign enq = in_xfer;
`endif

  // Buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and entry contents.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (enq) begin
          state_d = ONE;
          m_d     = dec;
        end
      end
      ONE: begin
        if (enq && out_xfer) begin
          m_d = dec;
        end else if (enq) begin
          state_d = FULL;
          s_d     = dec;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Entry storage and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

`ifdef SHIFT_ISSUE_ERR_EN
  logic err_q;

  // One-cycle pulse for an accepted illegal op.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= in_xfer & illegal;
  end

  assign err = err_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sh_in     = m_q.val;
  assign sh_shamt  = DATA_W'(m_q.shamt);
  assign sh_dir    = m_q.dir;
  assign sh_aorl   = m_q.aorl;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage; honours SHIFT_ISSUE_ERR_EN if defined at build.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  imm_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_in;
  logic [31:0] sh_shamt;
  logic        sh_dir;
  logic        sh_aorl;
`ifdef SHIFT_ISSUE_ERR_EN
  logic        err;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] shamt;
    logic        dir;
    logic        aorl;
  } exp_t;

  exp_t q[$];
  logic err_exp;

  shift_issue_stage #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .imm_shamt (imm_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sh_in     (sh_in),
    .sh_shamt  (sh_shamt),
    .sh_dir    (sh_dir),
    .sh_aorl   (sh_aorl)
`ifdef SHIFT_ISSUE_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // Reference shifter behaviour.
  function automatic logic [31:0] shf(input logic [31:0] a, input logic [31:0] s,
                                      input logic d, input logic ar);
    if (d)       return a << s[4:0];
    else if (ar) return 32'($signed(a) >>> s[4:0]);
    else         return a >> s[4:0];
  endfunction

  function automatic bit is_legal(input logic [2:0] f);
    return !(f == 3'd3 || f == 3'd7);
  endfunction

  // Expected shifter controls from the op table.
  function automatic exp_t ref_decode(input logic [2:0] f, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [4:0] imm);
    exp_t e;
    e.val = rt;
    case (f)
      3'd0: begin e.shamt = {27'd0, imm};     e.dir = 1'b1; e.aorl = 1'b0; end
      3'd1: begin e.shamt = {27'd0, imm};     e.dir = 1'b0; e.aorl = 1'b0; end
      3'd2: begin e.shamt = {27'd0, imm};     e.dir = 1'b0; e.aorl = 1'b1; end
      3'd4: begin e.shamt = {27'd0, rs[4:0]}; e.dir = 1'b1; e.aorl = 1'b0; end
      3'd5: begin e.shamt = {27'd0, rs[4:0]}; e.dir = 1'b0; e.aorl = 1'b0; end
      3'd6: begin e.shamt = {27'd0, rs[4:0]}; e.dir = 1'b0; e.aorl = 1'b1; end
      default: begin e.shamt = 32'd0;        e.dir = 1'b1; e.aorl = 1'b0; end
    endcase
    return e;
  endfunction

  // Apply one cycle of stimulus at negedge, clock it, update the model, return at next negedge.
  task automatic drive_cycle(input logic v, input logic [2:0] f, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [4:0] imm, input logic ordy);
    bit acc, pop;
    in_valid  = v;
    funct     = f;
    rs_val    = rs;
    rt_val    = rt;
    imm_shamt = imm;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    err_exp = 1'b0;
    if (acc) begin
`ifdef SHIFT_ISSUE_ERR_EN
      if (is_legal(f)) q.push_back(ref_decode(f, rs, rt, imm));
      else             err_exp = 1'b1;
`else
      q.push_back(ref_decode(f, rs, rt, imm));
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct = '0; rs_val = '0; rt_val = '0; imm_shamt = '0;
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (sh_in !== 32'd0 || sh_shamt !== 32'd0 || sh_dir !== 1'b0 || sh_aorl !== 1'b0)
      $display("FAIL reset_sh: in=%h shamt=%h dir=%b aorl=%b want all 0", sh_in, sh_shamt, sh_dir, sh_aorl);
    else pass_cnt++;
`ifdef SHIFT_ISSUE_ERR_EN
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: err=%b want 0", err); else pass_cnt++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops;
    logic [31:0] r;
    drive_cycle(1'b1, 3'd0, 32'd0, 32'd4567, 5'd4, 1'b1);
    r = shf(sh_in, sh_shamt, sh_dir, sh_aorl);
    chk_cnt++;
    if (out_valid !== 1'b1 || sh_dir !== 1'b1 || sh_aorl !== 1'b0 || sh_shamt !== 32'd4 || r !== 32'd73072)
      $display("FAIL sll_imm: v=%b dir=%b aorl=%b shamt=%0d res=%0d want 1/1/0/4/73072", out_valid, sh_dir, sh_aorl, sh_shamt, r);
    else pass_cnt++;
    drive_cycle(1'b1, 3'd1, 32'd0, 32'd4567, 5'd4, 1'b1);
    r = shf(sh_in, sh_shamt, sh_dir, sh_aorl);
    chk_cnt++;
    if (out_valid !== 1'b1 || r !== 32'd285) $display("FAIL srl_imm: v=%b res=%0d want 1/285", out_valid, r);
    else pass_cnt++;
    drive_cycle(1'b1, 3'd6, 32'hFFFF_FFE4, 32'hFFFF_FFC0, 5'd0, 1'b1);
    r = shf(sh_in, sh_shamt, sh_dir, sh_aorl);
    chk_cnt++;
    if (out_valid !== 1'b1 || sh_shamt !== 32'd4 || sh_aorl !== 1'b1 || sh_dir !== 1'b0 || r !== 32'hFFFF_FFFC)
      $display("FAIL srav: v=%b shamt=%0d aorl=%b dir=%b res=%h want 1/4/1/0/fffffffc", out_valid, sh_shamt, sh_aorl, sh_dir, r);
    else pass_cnt++;
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL drain1: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure;
    logic [31:0] a = 32'hA, b = 32'hB, c = 32'hC;
    drive_cycle(1'b1, 3'd0, 32'd0, a, 5'd1, 1'b0);
    drive_cycle(1'b1, 3'd0, 32'd0, b, 5'd1, 1'b0);
    chk_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sh_in !== a)
      $display("FAIL bp_full: in_ready=%b out_valid=%b sh_in=%h want 0/1/%h", in_ready, out_valid, sh_in, a);
    else pass_cnt++;
    drive_cycle(1'b1, 3'd0, 32'd0, c, 5'd1, 1'b0);
    chk_cnt++;
    if (in_ready !== 1'b0 || sh_in !== a) $display("FAIL bp_hold: in_ready=%b sh_in=%h want 0/%h", in_ready, sh_in, a);
    else pass_cnt++;
    drive_cycle(1'b1, 3'd0, 32'd0, c, 5'd1, 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b1 || sh_in !== b || in_ready !== 1'b1)
      $display("FAIL bp_drainB: v=%b sh_in=%h in_ready=%b want 1/%h/1", out_valid, sh_in, in_ready, b);
    else pass_cnt++;
    drive_cycle(1'b1, 3'd0, 32'd0, c, 5'd1, 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b1 || sh_in !== c) $display("FAIL bp_drainC: v=%b sh_in=%h want 1/%h", out_valid, sh_in, c);
    else pass_cnt++;
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_illegal;
    drive_cycle(1'b1, 3'd3, 32'd0, 32'd7, 5'd9, 1'b1);
`ifdef SHIFT_ISSUE_ERR_EN
    chk_cnt++;
    if (err !== 1'b1 || out_valid !== 1'b0) $display("FAIL illegal_err: err=%b out_valid=%b want 1/0", err, out_valid);
    else pass_cnt++;
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk_cnt++;
    if (err !== 1'b0 || out_valid !== 1'b0) $display("FAIL illegal_pulse: err=%b out_valid=%b want 0/0", err, out_valid);
    else pass_cnt++;
`else
    chk_cnt++;
    if (out_valid !== 1'b1 || sh_shamt !== 32'd0 || sh_dir !== 1'b1 || shf(sh_in, sh_shamt, sh_dir, sh_aorl) !== 32'd7)
      $display("FAIL illegal_pass: v=%b shamt=%0d dir=%b res=%0d want 1/0/1/7", out_valid, sh_shamt, sh_dir, shf(sh_in, sh_shamt, sh_dir, sh_aorl));
    else pass_cnt++;
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
`endif
  endtask

  task automatic test_reset_mid_stream;
    drive_cycle(1'b1, 3'd1, 32'd0, 32'h1111, 5'd2, 1'b0);
    drive_cycle(1'b1, 3'd1, 32'd0, 32'h2222, 5'd2, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL midrst_replay: cycle %0d out_valid=%b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom), 1'($urandom_range(0, 2) != 0));
      chk_cnt++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
        $display("FAIL rand_hs: cyc %0d out_valid=%b in_ready=%b want %b/%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2);
      else pass_cnt++;
      if (q.size() > 0) begin
        chk_cnt++;
        if ({sh_in, sh_shamt, sh_dir, sh_aorl} !== {q[0].val, q[0].shamt, q[0].dir, q[0].aorl})
          $display("FAIL rand_op: cyc %0d got %h/%0d/%b/%b want %h/%0d/%b/%b", i, sh_in, sh_shamt, sh_dir, sh_aorl,
                   q[0].val, q[0].shamt, q[0].dir, q[0].aorl);
        else pass_cnt++;
      end
`ifdef SHIFT_ISSUE_ERR_EN
      chk_cnt++;
      if (err !== err_exp) $display("FAIL rand_err: cyc %0d err=%b want %b", i, err, err_exp);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    err_exp = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_ops();
    test_back_pressure();
    test_illegal();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
